// File: rtl/mux_scan_pkg.sv
// mux_scan_pkg: shared state type and sizes for the mux scan sequencer
package mux_scan_pkg;
  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
  localparam int N_IN = 8;
  localparam int SEL_W = 3;
endpackage

// File: rtl/mux_scan_sequencer_if.sv
// mux_scan_sequencer_if: scan request, mux select and word handshake; parity only with MUX_SCAN_PARITY_EN
interface mux_scan_sequencer_if;
  import mux_scan_pkg::*;
  logic start, mux_in, busy, word_valid, word_ready;
  logic [SEL_W-1:0] sel;
  logic [N_IN-1:0] word;
`ifdef MUX_SCAN_PARITY_EN
  logic parity;
  modport master(input start, mux_in, word_ready, output sel, busy, word, word_valid, parity);
  modport slave(output start, mux_in, word_ready, input sel, busy, word, word_valid, parity);
`else
  modport master(input start, mux_in, word_ready, output sel, busy, word, word_valid);
  modport slave(output start, mux_in, word_ready, input sel, busy, word, word_valid);
`endif
endinterface

// File: rtl/mux_scan_ctr.sv
// mux_scan_ctr: scan step counter; wraps to 0 after the last step
module mux_scan_ctr
  import mux_scan_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             enable,
  output logic [SEL_W-1:0] idx,
  output logic             last
);
  always_ff @(posedge clk)
    idx <= (!rst_n || clear) ? '0 : enable ? idx + 1'b1 : idx;
  assign last = idx == SEL_W'(N_IN - 1);
endmodule

// File: rtl/mux_scan_sequencer.sv
// mux_scan_sequencer: steps an 8:1 bit mux through all selects and assembles the sampled word.
// Define MUX_SCAN_PARITY_EN to add a registered parity output over the word.
module mux_scan_sequencer
  import mux_scan_pkg::*;
#(
  parameter bit MSB_FIRST = 0
) (
  input logic clk,
  input logic rst_n,
  mux_scan_sequencer_if.master bus
);
  state_t state;
  logic [N_IN-1:0] shadow, shadow_nxt;
  logic [SEL_W-1:0] idx;
  logic last;
  mux_scan_ctr u_ctr (
    .clk, .rst_n, .clear(state != SCAN), .enable(state == SCAN), .idx, .last
  );
  // idx rests at 0 outside SCAN, so sel parks at the first select of the scan order
  assign bus.sel = MSB_FIRST ? SEL_W'(N_IN - 1) - idx : idx;
  always_comb begin
    shadow_nxt = shadow;
    shadow_nxt[bus.sel] = bus.mux_in;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      shadow <= '0;
      bus.busy <= 1'b0;
      bus.word <= '0;
      bus.word_valid <= 1'b0;
`ifdef MUX_SCAN_PARITY_EN
      bus.parity <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (bus.start) begin
          state <= SCAN;
          bus.busy <= 1'b1;
        end
        SCAN: begin
          shadow <= shadow_nxt;
          if (last) begin
            state <= DONE;
            bus.busy <= 1'b0;
            bus.word <= shadow_nxt;
            bus.word_valid <= 1'b1;
`ifdef MUX_SCAN_PARITY_EN
            bus.parity <= ^shadow_nxt;
`endif
          end
        end
        DONE: if (bus.word_ready) begin
          state <= bus.start ? SCAN : IDLE;
          bus.busy <= bus.start;
          bus.word_valid <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mux_scan_sequencer.sv
// tb_mux_scan_sequencer: directed and random scans on LSB-first and MSB-first instances against a scan-order model
module tb_mux_scan_sequencer;
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;
  mux_scan_sequencer_if b0 ();
  mux_scan_sequencer_if b1 ();
  logic [7:0] pat0 = 8'h00, pat1 = 8'h00;
  assign b0.mux_in = pat0[b0.sel];
  assign b1.mux_in = pat1[b1.sel];
  mux_scan_sequencer #(.MSB_FIRST(0)) d0 (.clk(clk), .rst_n(rst_n), .bus(b0.master));
  mux_scan_sequencer #(.MSB_FIRST(1)) d1 (.clk(clk), .rst_n(rst_n), .bus(b1.master));
  int errs = 0, checks = 0;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_sel(bit u, int i);
    return u ? 32'(7 - i) : 32'(i);
  endfunction
  function automatic logic [7:0] rd_word(bit u);
    return u ? b1.word : b0.word;
  endfunction
  function automatic logic [2:0] rd_sel(bit u);
    return u ? b1.sel : b0.sel;
  endfunction
  function automatic logic rd_busy(bit u);
    return u ? b1.busy : b0.busy;
  endfunction
  function automatic logic rd_valid(bit u);
    return u ? b1.word_valid : b0.word_valid;
  endfunction

  task automatic set_in(bit u, logic [7:0] p);
    if (u) pat1 = p; else pat0 = p;
  endtask
  task automatic set_ctl(bit u, logic s, logic r);
    if (u) begin b1.start = s; b1.word_ready = r; end
    else begin b0.start = s; b0.word_ready = r; end
  endtask

  task automatic kick(bit u);
    set_ctl(u, 1'b1, 1'b0);
    @(negedge clk);
    set_ctl(u, 1'b0, 1'b0);
  endtask

  task automatic chk_reset(bit u);
    chk("rst_word", rd_word(u), 0);
    chk("rst_valid", rd_valid(u), 0);
    chk("rst_busy", rd_busy(u), 0);
    chk("rst_sel", rd_sel(u), exp_sel(u, 0));
`ifdef MUX_SCAN_PARITY_EN
    chk("rst_parity", u ? b1.parity : b0.parity, 0);
`endif
  endtask

  // Entered at the first SCAN cycle; the mux holds p for the whole scan.
  task automatic do_scan(bit u, logic [7:0] p, int stall, int pulse_at, bit chain, logic [7:0] alt);
    set_in(u, p);
    for (int i = 0; i < 8; i++) begin
      chk("scan_busy", rd_busy(u), 1);
      chk("scan_sel", rd_sel(u), exp_sel(u, i));
      chk("scan_valid", rd_valid(u), 0);
      set_ctl(u, i == pulse_at, 1'b0);
      @(negedge clk);
    end
    set_ctl(u, 1'b0, 1'b0);
    chk("done_valid", rd_valid(u), 1);
    chk("done_word", rd_word(u), p);
    chk("done_busy", rd_busy(u), 0);
    chk("done_sel", rd_sel(u), exp_sel(u, 0));
`ifdef MUX_SCAN_PARITY_EN
    chk("done_parity", u ? b1.parity : b0.parity, ^p);
`endif
    set_in(u, alt);
    for (int i = 0; i < stall; i++) begin
      set_ctl(u, 1'b1, 1'b0);
      @(negedge clk);
      chk("hold_valid", rd_valid(u), 1);
      chk("hold_word", rd_word(u), p);
      chk("hold_busy", rd_busy(u), 0);
    end
    set_ctl(u, chain, 1'b1);
    @(negedge clk);
    set_ctl(u, 1'b0, 1'b0);
    chk("acc_valid", rd_valid(u), 0);
    chk("acc_word", rd_word(u), p);
    chk("acc_busy", rd_busy(u), chain);
    chk("acc_sel", rd_sel(u), exp_sel(u, 0));
  endtask

  initial begin
    bit u, ch;
    bit chained;
    set_ctl(0, 1'b0, 1'b0);
    set_ctl(1, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    chk_reset(0);
    chk_reset(1);
    rst_n = 1'b1;
    kick(0);
    do_scan(0, 8'hA5, 5, -1, 0, 8'hFF);
    kick(1);
    do_scan(1, 8'h3C, 0, -1, 0, 8'h00);
    kick(0);
    do_scan(0, 8'h5A, 2, 3, 1, 8'h00);
    do_scan(0, 8'hC3, 0, -1, 0, 8'h00);
    kick(0);
    do_scan(0, 8'h07, 0, -1, 0, 8'h00);
    kick(0);
    do_scan(0, 8'h03, 1, -1, 0, 8'h00);
    kick(1);
    do_scan(1, 8'h96, 0, -1, 0, 8'h00);
    kick(0);
    set_in(0, 8'hE7);
    repeat (4) @(negedge clk);
    chk("mid_sel", rd_sel(0), 4);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk_reset(0);
    chk_reset(1);
    kick(0);
    do_scan(0, 8'h6D, 0, -1, 0, 8'h00);
    chained = 1'b0;
    u = 1'b0;
    for (int n = 0; n < 24; n++) begin
      if (!chained) begin
        u = 1'($urandom_range(0, 1));
        kick(u);
      end
      ch = 1'($urandom_range(0, 1));
      do_scan(u, 8'($urandom), int'($urandom_range(0, 3)), int'($urandom_range(0, 9)), ch, 8'($urandom));
      chained = ch;
    end
    if (chained) do_scan(u, 8'($urandom), 0, -1, 0, 8'h00);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/mux_scan_sequencer.md
MUX_SCAN_SEQUENCER -- requirements
Module: mux_scan_sequencer

Interface
REQ-001 SHALL provide parameter MSB_FIRST, default 0, scan order: 0 = sel 0..7, 1 = sel 7..0.
REQ-002 SHALL provide port clk  input  1  single system clock; all state on rising edge.
REQ-003 SHALL provide port rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL provide port start  input  1  request one 8-bit scan; sampled only as stated in REQ-011 and REQ-015.
REQ-005 SHALL provide port mux_in  input  1  output bit of the downstream 8:1 bit mux, a combinational function of sel.
REQ-006 SHALL provide port sel  output  3  select code driven to the 8:1 bit mux.
REQ-007 SHALL provide port busy  output  1  high while in SCAN.
REQ-008 SHALL provide port word  output  8  assembled word, word[k] = mux_in sampled while sel == k.
REQ-009 SHALL provide port word_valid  output  1  word available; held until accepted.
REQ-010 SHALL provide port word_ready  input  1  consumer accepts word when word_valid && word_ready at a clock edge.

Function
REQ-011 SHALL implement FSM IDLE -> SCAN on start; SCAN -> DONE after the 8th sample; DONE -> IDLE on accept.
REQ-012 SHALL keep a registered 3-bit step counter idx; sel = idx when MSB_FIRST=0, sel = 7 - idx when MSB_FIRST=1; sel = 0 (MSB_FIRST=0) or 7 (MSB_FIRST=1) outside SCAN.
REQ-013 SHALL, on each SCAN edge, write mux_in into shadow bit shadow[sel], then increment idx; idx wraps 7 -> 0 on the transition to DONE.
REQ-014 SHALL copy shadow to word and assert word_valid on the edge that takes the 8th sample; latency is start-edge to word_valid-high = 9 cycles (8 SCAN cycles + 1).
REQ-015 SHALL, in DONE with word_valid && word_ready && start at the same edge, go directly to SCAN with idx = 0 (no IDLE bubble); without start, go to IDLE.
REQ-016 SHALL ignore start while in SCAN, and while in DONE without word_ready.
REQ-017 SHALL hold word and word_valid stable while word_valid && !word_ready.
REQ-018 SHALL deassert word_valid on accept; word retains its last value until the next completion.
REQ-019 SHALL NOT clear shadow between scans; every bit is overwritten during each scan.

Reset
REQ-020 SHALL, when rst_n is low at a clock edge, set state = IDLE, idx = 0, shadow = 0, word = 8'h00, word_valid = 0, busy = 0, and parity = 0 if present.
REQ-021 SHALL abort a scan when reset occurs mid-SCAN; no partial word is delivered and the first post-reset start begins at idx = 0.

Configuration
REQ-022 SHALL compile in, when MUX_SCAN_PARITY_EN is defined, an output port parity (1 bit) = XOR of the 8 bits of word, registered and updated on the same edge as word.
REQ-023 SHALL, when MUX_SCAN_PARITY_EN is undefined, omit the parity port and its logic entirely, with all other behaviour identical.

Structure
REQ-024 SHALL take from shared package mux_scan_pkg: the state enum (IDLE, SCAN, DONE), N_IN = 8, and SEL_W = 3.
REQ-025 SHALL place the step counter in sub-module mux_scan_ctr (inputs: clear, enable; outputs: idx, last), instantiated once.

Verification
REQ-026 SHALL cover: MSB_FIRST=0, mux inputs 8'hA5, start pulsed 1 cycle -> sel 0,1,...,7 on cycles 1-8, word = 8'hA5, word_valid high on cycle 9.
REQ-027 SHALL cover: MSB_FIRST=1, mux inputs 8'h3C -> sel 7,6,...,0, word = 8'h3C after 9 cycles.
REQ-028 SHALL cover: word_ready held low 5 cycles after completion, inputs changed to 8'hFF meanwhile -> word stays 8'hA5, word_valid stays high; accepted on cycle 6 of DONE.
REQ-029 SHALL cover: start re-pulsed at idx = 3, and start high with word_ready on the accept edge -> the first is ignored; the second yields busy high on the next cycle with sel = 0.
REQ-030 SHALL cover: rst_n low at idx = 4 -> next cycle word = 8'h00, word_valid = 0, busy = 0; a subsequent start produces a full 9-cycle scan.
REQ-031 SHALL cover: MUX_SCAN_PARITY_EN defined, inputs 8'h07 -> parity = 1; inputs 8'h03 -> parity = 0.
